fifo_protocol_checker: RTL and testbench

FIFO_PROTOCOL_CHECKER -- requirements
Module: fifo_protocol_checker

---
 rtl/fifo_protocol_checker.sv | 238 +++++++++++++++++++++++
 tb/tb_fifo_protocol_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_protocol_checker.sv
// fifo_protocol_checker
// Passive monitor for a single-clock FIFO. It keeps its own model of the FIFO
// occupancy from the write/read strobes and reports protocol, data-range,
// status-flag and repeated-data violations. Errors are reported one cycle
// after detection as per-code pulses, sticky bits, a saturating event count,
// and a capture of the first error seen since reset or clear.
module fifo_protocol_checker #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int LO      = 29,
  parameter int HI      = 102,
  parameter int RUN_MAX = 10,
  parameter int RD_LAT  = 1,
  parameter int CNT_W   = 16
) (
  input  logic                       wclk,
  input  logic                       wreset,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       we,
  input  logic                       re,
  input  logic [DATA_W-1:0]          datain,
  input  logic [DATA_W-1:0]          dataout,
  input  logic                       full,
  input  logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic [5:0]                 err_pulse,
  output logic [5:0]                 err_sticky,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [2:0]                 first_code,
  output logic [DATA_W-1:0]          first_data,
  output logic                       first_vld
);

  localparam int                OCC_W    = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);
  localparam int                RUN_W    = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0]  RUN_LIM  = RUN_W'(RUN_MAX);
  localparam logic [DATA_W-1:0] LO_V     = DATA_W'(LO);
  localparam logic [DATA_W-1:0] HI_V     = DATA_W'(HI);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // Error code bit positions
  localparam int E_OVF    = 0;
  localparam int E_UDF    = 1;
  localparam int E_WRANGE = 2;
  localparam int E_RRANGE = 3;
  localparam int E_FLAG   = 4;
  localparam int E_RUN    = 5;

  // Inclusive legal data window
  function automatic logic in_range(input logic [DATA_W-1:0] v);
    return (v >= LO_V) && (v <= HI_V);
  endfunction

  // Number of error codes raised in one cycle
  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Counter add that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [2:0]       b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(b);
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  // Lowest-numbered set code; caller guarantees at least one bit is set
  function automatic logic [2:0] lowest_code(input logic [5:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 5; i >= 0; i--) begin
      if (v[i]) c = 3'(i);
    end
    return c;
  endfunction

  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              rd_vld_q;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [DATA_W-1:0] run_data_q, run_data_d;
  logic              run_hit;

  logic [5:0]        err_pulse_q, err_pulse_d;
  logic [5:0]        err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [2:0]        first_code_q, first_code_d;
  logic [DATA_W-1:0] first_data_q, first_data_d;
  logic              first_vld_q, first_vld_d;

  logic              occ_is_full, occ_is_empty;
  logic              acc_wr, acc_rd;
  logic              rd_data_cycle;
  logic [5:0]        det, rep;
  logic [2:0]        cap_code;

  assign occ_is_full  = (occ_q == OCC_FULL);
  assign occ_is_empty = (occ_q == '0);

  // A write into a full FIFO or a read from an empty one is rejected, so at
  // the two extremes only the legal half of a simultaneous we/re is accepted.
  assign acc_wr = we & ~occ_is_full;
  assign acc_rd = re & ~occ_is_empty;

  // Read data is checked in the cycle it is presented on dataout
  generate
    if (RD_LAT == 0) begin : g_rd_lat0
      assign rd_data_cycle = acc_rd;
    end else begin : g_rd_lat1
      assign rd_data_cycle = rd_vld_q;
    end
  endgenerate

  // Occupancy next state from accepted transfers
  always_comb begin
    occ_d = occ_q;
    case ({acc_wr, acc_rd})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Run tracker: a count of 0 means no run in progress, so the next accepted
  // write always starts a fresh run regardless of the stored value.
  always_comb begin
    logic [RUN_W-1:0] run_next;
    run_cnt_d  = run_cnt_q;
    run_data_d = run_data_q;
    run_hit    = 1'b0;
    run_next   = '0;
    if (acc_wr) begin
      if ((run_cnt_q != '0) && (datain == run_data_q)) begin
        run_next = run_cnt_q + RUN_W'(1);
      end else begin
        run_next = RUN_W'(1);
      end
      run_data_d = datain;
      if (run_next == RUN_LIM) begin
        run_hit   = 1'b1;
        run_cnt_d = '0;
      end else begin
        run_cnt_d = run_next;
      end
    end
  end

  // Raw violation detection for the current cycle
  always_comb begin
    det           = '0;
    det[E_OVF]    = we & occ_is_full;
    det[E_UDF]    = re & occ_is_empty;
    det[E_WRANGE] = we & ~in_range(datain);
    det[E_RRANGE] = rd_data_cycle & ~in_range(dataout);
    det[E_FLAG]   = (full != occ_is_full) | (empty != occ_is_empty);
    det[E_RUN]    = run_hit;
  end

  assign rep      = en ? det : 6'b000000;
  assign cap_code = lowest_code(rep);

  // Error reporting next state; clear overrides anything detected this cycle
  always_comb begin
    err_pulse_d  = err_pulse_q;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    first_code_d = first_code_q;
    first_data_d = first_data_q;
    first_vld_d  = first_vld_q;
    if (clr) begin
      err_pulse_d  = '0;
      err_sticky_d = '0;
      err_cnt_d    = '0;
      first_code_d = '0;
      first_data_d = '0;
      first_vld_d  = 1'b0;
    end else begin
      err_pulse_d  = rep;
      err_sticky_d = err_sticky_q | rep;
      err_cnt_d    = sat_add(err_cnt_q, popcount6(rep));
      if (!first_vld_q && (rep != '0)) begin
        first_vld_d  = 1'b1;
        first_code_d = cap_code;
        first_data_d = ((cap_code == 3'(E_UDF)) || (cap_code == 3'(E_RRANGE)))
                       ? dataout : datain;
      end
    end
  end

  // Occupancy, run tracker and read-valid state
  always_ff @(posedge wclk or negedge wreset) begin
    if (!wreset) begin
      occ_q      <= '0;
      rd_vld_q   <= 1'b0;
      run_cnt_q  <= '0;
      run_data_q <= '0;
    end else begin
      occ_q      <= occ_d;
      rd_vld_q   <= acc_rd;
      run_cnt_q  <= run_cnt_d;
      run_data_q <= run_data_d;
    end
  end

  // Reported error state
  always_ff @(posedge wclk or negedge wreset) begin
    if (!wreset) begin
      err_pulse_q  <= '0;
      err_sticky_q <= '0;
      err_cnt_q    <= '0;
      first_code_q <= '0;
      first_data_q <= '0;
      first_vld_q  <= 1'b0;
    end else begin
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      first_code_q <= first_code_d;
      first_data_q <= first_data_d;
      first_vld_q  <= first_vld_d;
    end
  end

  assign occ        = occ_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign first_code = first_code_q;
  assign first_data = first_data_q;
  assign first_vld  = first_vld_q;

endmodule

// File: tb/tb_fifo_protocol_checker.sv
// Bench for fifo_protocol_checker: directed stimulus, a behavioural model of
// the checking rules, a per-cycle compare process and literal spot checks.
module tb_fifo_protocol_checker;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int LO      = 29;
  localparam int HI      = 102;
  localparam int RUN_MAX = 10;
  localparam int RD_LAT  = 1;
  localparam int CNT_W   = 5;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic              wclk, wreset, en, clr, we, re, full, empty;
  logic [DATA_W-1:0] datain, dataout;
  logic [2:0]        occ;
  logic [5:0]        err_pulse, err_sticky;
  logic [CNT_W-1:0]  err_cnt;
  logic [2:0]        first_code;
  logic [DATA_W-1:0] first_data;
  logic              first_vld;

  fifo_protocol_checker #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .LO(LO), .HI(HI),
    .RUN_MAX(RUN_MAX), .RD_LAT(RD_LAT), .CNT_W(CNT_W)
  ) dut (
    .wclk(wclk), .wreset(wreset), .en(en), .clr(clr), .we(we), .re(re),
    .datain(datain), .dataout(dataout), .full(full), .empty(empty),
    .occ(occ), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_cnt(err_cnt), .first_code(first_code), .first_data(first_data),
    .first_vld(first_vld)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit force_full = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_occ, m_len, m_cnt;
  int       m_val;
  bit       m_rdp;
  bit [5:0] m_pulse, m_sticky;
  int       m_fcode, m_fdata;
  bit       m_fvld;

  bit       aw, ar;
  bit [5:0] d;
  int       n_len, n_val, n_occ, lowc;

  always_comb begin
    aw = we && (m_occ < DEPTH);
    ar = re && (m_occ > 0);
    d = '0;
    d[0] = we && (m_occ == DEPTH);
    d[1] = re && (m_occ == 0);
    d[2] = we && ((datain < LO) || (datain > HI));
    d[3] = m_rdp && ((dataout < LO) || (dataout > HI));
    d[4] = (full != (m_occ == DEPTH)) || (empty != (m_occ == 0));
    n_len = m_len;
    n_val = m_val;
    if (aw) begin
      if (m_len > 0 && int'(datain) == m_val) n_len = m_len + 1;
      else begin
        n_len = 1;
        n_val = int'(datain);
      end
      if (n_len == RUN_MAX) begin
        d[5] = 1'b1;
        n_len = 0;
      end
    end
    n_occ = m_occ + int'(aw) - int'(ar);
    lowc = 0;
    for (int i = 5; i >= 0; i--) if (d[i]) lowc = i;
  end

  always @(posedge wclk or negedge wreset) begin
    if (!wreset) begin
      m_occ <= 0; m_len <= 0; m_val <= 0; m_rdp <= 1'b0;
      m_pulse <= '0; m_sticky <= '0; m_cnt <= 0;
      m_fcode <= 0; m_fdata <= 0; m_fvld <= 1'b0;
    end else begin
      m_occ <= n_occ;
      m_rdp <= ar;
      m_len <= n_len;
      m_val <= n_val;
      if (clr) begin
        m_pulse <= '0; m_sticky <= '0; m_cnt <= 0;
        m_fcode <= 0; m_fdata <= 0; m_fvld <= 1'b0;
      end else if (en) begin
        m_pulse  <= d;
        m_sticky <= m_sticky | d;
        m_cnt    <= (m_cnt + $countones(d) > CMAX) ? CMAX : m_cnt + $countones(d);
        if (!m_fvld && d != 0) begin
          m_fvld  <= 1'b1;
          m_fcode <= lowc;
          m_fdata <= (lowc == 1 || lowc == 3) ? int'(dataout) : int'(datain);
        end
      end else begin
        m_pulse <= '0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge wclk) begin
    if (chk_en) begin
      chk("occ",        occ,        m_occ);
      chk("err_pulse",  err_pulse,  m_pulse);
      chk("err_sticky", err_sticky, m_sticky);
      chk("err_cnt",    err_cnt,    m_cnt);
      chk("first_vld",  first_vld,  m_fvld);
      chk("first_code", first_code, m_fcode);
      chk("first_data", first_data, m_fdata);
    end
  end

  // ---------------- stimulus ----------------
  // One cycle: drive strobes and consistent flags, return 1 time unit after the edge
  task automatic step(input bit w, input bit r, input logic [DATA_W-1:0] di);
    we = w; re = r; datain = di;
    full  = force_full | (m_occ == DEPTH);
    empty = (m_occ == 0);
    @(posedge wclk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1'b0, 1'b0, 8'd50);
    clr = 1'b0;
  endtask

  int run_pulses;

  initial begin
    wreset = 1'b1; en = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
    datain = 8'd50; dataout = 8'd50; full = 1'b0; empty = 1'b1;
    #2 wreset = 1'b0;
    #10 wreset = 1'b1;
    @(posedge wclk);
    #1;
    chk_en = 1'b1;
    chk("reset_occ", occ, 0);
    chk("reset_cnt", err_cnt, 0);
    chk("reset_fvld", first_vld, 0);

    // Overflow on the fifth write into a depth-4 FIFO
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'd50);
    chk("ovf_pulse", err_pulse, 6'b000001);
    chk("ovf_occ", occ, 4);
    chk("ovf_fcode", first_code, 0);
    chk("ovf_fdata", first_data, 50);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'd50);
    step(1'b0, 1'b0, 8'd50);
    chk("drain_cnt", err_cnt, 1);
    do_clr();
    chk("clr_cnt", err_cnt, 0);

    // Simultaneous write and read on an empty FIFO
    step(1'b1, 1'b1, 8'd40);
    chk("udf_pulse", err_pulse, 6'b000010);
    chk("udf_occ", occ, 1);
    chk("udf_fcode", first_code, 1);
    chk("udf_fdata", first_data, 50);
    step(1'b0, 1'b1, 8'd50);
    step(1'b0, 1'b0, 8'd50);
    do_clr();

    // Out-of-range write, then the same value read back
    step(1'b1, 1'b0, 8'd28);
    chk("wrange_pulse", err_pulse, 6'b000100);
    step(1'b0, 1'b0, 8'd50);
    dataout = 8'd28;
    step(1'b0, 1'b1, 8'd50);
    chk("rrange_early", err_pulse, 6'b000000);
    step(1'b0, 1'b0, 8'd50);
    chk("rrange_pulse", err_pulse, 6'b001000);
    chk("rrange_cnt", err_cnt, 2);
    dataout = 8'd50;
    do_clr();

    // Twenty accepted writes of 77 with reads interleaved
    run_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (m_occ > 0), 8'd77);
      if (err_pulse[5]) run_pulses++;
      if (i == 9) chk("run_10th", err_pulse[5], 1);
      if (i == 10) chk("run_11th", err_pulse[5], 0);
    end
    chk("run_total", run_pulses, 2);
    step(1'b0, 1'b1, 8'd50);
    step(1'b0, 1'b0, 8'd50);
    do_clr();

    // Wrong full flag held at occupancy 2 until the counter saturates
    step(1'b1, 1'b0, 8'd30);
    step(1'b1, 1'b0, 8'd31);
    force_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 8'd50);
      if (i == 2) chk("flag_cnt3", err_cnt, 3);
    end
    chk("flag_pulse", err_pulse, 6'b010000);
    chk("flag_sat", err_cnt, CMAX);
    force_full = 1'b0;
    step(1'b0, 1'b0, 8'd50);
    chk("flag_gone", err_pulse, 6'b000000);

    // Clear with an overflow present, then overflow with checking disabled
    step(1'b1, 1'b0, 8'd32);
    step(1'b1, 1'b0, 8'd33);
    clr = 1'b1;
    step(1'b1, 1'b0, 8'd34);
    clr = 1'b0;
    chk("clr_sticky", err_sticky, 0);
    chk("clr_cnt2", err_cnt, 0);
    chk("clr_fvld", first_vld, 0);
    chk("clr_occ", occ, 4);
    en = 1'b0;
    step(1'b1, 1'b0, 8'd35);
    chk("dis_pulse", err_pulse, 0);
    step(1'b0, 1'b1, 8'd50);
    chk("dis_occ", occ, 3);
    chk("dis_cnt", err_cnt, 0);
    en = 1'b1;
    step(1'b0, 1'b0, 8'd50);

    // Reset while a bad read-data cycle is in flight
    dataout = 8'd28;
    step(1'b0, 1'b1, 8'd50);
    #2 wreset = 1'b0;
    #1 chk("async_occ", occ, 0);
    #2 wreset = 1'b1;
    step(1'b0, 1'b0, 8'd50);
    chk("rst_inflight", err_pulse, 0);
    dataout = 8'd50;
    step(1'b1, 1'b0, 8'd200);
    chk("post_rst_pulse", err_pulse, 6'b000100);
    chk("post_rst_fcode", first_code, 2);
    chk("post_rst_fdata", first_data, 200);
    step(1'b0, 1'b0, 8'd50);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
